// File: rtl/mag_comp_arb.sv
// mag_comp_arb: round-robin arbiter sharing one unsigned magnitude comparator among R requesters
module mag_comp_arb #(
    parameter int N    = 4,
    parameter int R    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    req,
    input  logic [R*N-1:0]  a_in,
    input  logic [R*N-1:0]  b_in,
    output logic [R-1:0]    gnt,
    output logic            busy,
    output logic            res_valid,
    output logic [ID_W-1:0] res_id,
    output logic            e,
    output logic            g,
    output logic            l
);
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t          state;
    logic [ID_W-1:0] ptr, win, sel;
    logic [N-1:0]    a_q, b_q;
    // Scan from the far end back toward ptr so the requester closest to ptr wins.
    always_comb begin
        sel = ptr;
        for (int k = R - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % R]) sel = ID_W'((int'(ptr) + k) % R);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            e         <= 1'b0;
            g         <= 1'b0;
            l         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state <= CMP;
                    win   <= sel;
                    a_q   <= a_in[sel*N +: N];
                    b_q   <= b_in[sel*N +: N];
                    gnt   <= R'(1) << sel;
                    busy  <= 1'b1;
                end
                CMP: begin
                    state     <= DONE;
                    gnt       <= '0;
                    res_valid <= 1'b1;
                    res_id    <= win;
                    e         <= a_q == b_q;
                    g         <= a_q > b_q;
                    l         <= a_q < b_q;
                    ptr       <= (int'(win) == R - 1) ? '0 : win + 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mag_comp_arb.sv
// tb_mag_comp_arb: directed bench with a result scoreboard for mag_comp_arb
module tb_mag_comp_arb;
    localparam int N = 4, R = 4, ID_W = 2;
    logic            clk = 1'b0, rst = 1'b1;
    logic [R-1:0]    req = '0;
    logic [R*N-1:0]  a_in = '0, b_in = '0;
    logic [R-1:0]    gnt;
    logic            busy, res_valid, e, g, l;
    logic [ID_W-1:0] res_id;
    int checks = 0, errors = 0;
    typedef struct packed {logic [ID_W-1:0] id; logic e, g, l;} exp_t;
    exp_t sb[$];
    exp_t got;

    always #5 clk = ~clk;

    mag_comp_arb #(.N(N), .R(R), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .e(e), .g(g), .l(l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_res_valid: observed res_id %0d expected no result", res_id);
            end else begin
                got = sb.pop_front();
                chk("res_id", res_id, got.id);
                chk("egl", {e, g, l}, {got.e, got.g, got.l});
            end
        end
        if (!busy) chk("gnt_idle", gnt, 0);
    end

    task automatic txn(input logic [R-1:0] r, input logic [R*N-1:0] a, input logic [R*N-1:0] b,
                       input logic [R*N-1:0] a_late, input int id);
        exp_t x;
        logic [N-1:0] av, bv;
        av = a[id*N +: N];
        bv = b[id*N +: N];
        x.id = ID_W'(id);
        x.e = av == bv;
        x.g = av > bv;
        x.l = av < bv;
        sb.push_back(x);
        req = r;
        a_in = a;
        b_in = b;
        @(negedge clk);
        chk("gnt", gnt, 32'(1) << id);
        chk("busy_cmp", busy, 1);
        req = '0;
        a_in = a_late;
        @(negedge clk);
        chk("busy_done", busy, 1);
        chk("res_valid", res_valid, 1);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("res_valid_idle", res_valid, 0);
    endtask

    initial begin
        logic [R*N-1:0] ra, rb, rl;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_egl", {e, g, l}, 0);
            chk("rst_res_id", res_id, 0);
        end
        ra = '0;
        rb = '0;
        ra[11:8] = 4'd9;
        rb[11:8] = 4'd3;
        txn(4'b0100, ra, rb, ra, 2);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                ra[3:0] = 4'(a);
                rb[3:0] = 4'(b);
                txn(4'b0001, ra, rb, ra, 0);
            end
        ra = 16'($urandom);
        rb = 16'($urandom);
        txn(4'b0010, ra, rb, ra, 1);
        txn(4'b1000, ra, rb, ra, 3);
        for (int k = 0; k < 12; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            txn(4'b1111, ra, rb, ra, k % 4);
        end
        txn(4'b0001, ra, rb, ra, 0);
        txn(4'b1001, ra, rb, ra, 3);
        txn(4'b1001, ra, rb, ra, 0);
        ra = 16'($urandom);
        rb = 16'($urandom);
        ra[7:4] = 4'd5;
        rb[7:4] = 4'd5;
        rl = ra;
        rl[7:4] = 4'd7;
        txn(4'b0010, ra, rb, rl, 1);
        req = 4'b0100;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        @(negedge clk);
        chk("mid_gnt", gnt, 4'b0100);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_res_valid2", res_valid, 0);
        ra = 16'($urandom);
        rb = 16'($urandom);
        txn(4'b0110, ra, rb, ra, 1);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
